// File: rtl/instr_encoder_if.sv
// Field-tuple input and encoded-word output bundle
// for the RV32 instruction encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  func7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [7:0]  err_count;

  modport master (
    output in_valid, fmt, opcode, rd, func3,
    output rs1, rs2, func7, imm, out_ready,
    input  in_ready, out_valid, out_instr,
    input  out_addr, err_count
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, func3,
    input  rs1, rs2, func7, imm, out_ready,
    output in_ready, out_valid, out_instr,
    output out_addr, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32 field-tuple to instruction-word encoder with an
// output FIFO and a sequential byte address per word.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  instr_encoder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] last_q, last_d;
  logic [7:0]  err_q, err_d;

  logic        is_r, is_i, is_s;
  logic        is_b, is_u, is_j;
  logic [31:0] enc;
  logic        bad;
  logic        full, empty;
  logic        acc, push, pop;

  always_comb begin
    is_r = (bus.fmt == 3'd0);
    is_i = (bus.fmt == 3'd1);
    is_s = (bus.fmt == 3'd2);
    is_b = (bus.fmt == 3'd3);
    is_u = (bus.fmt == 3'd4);
    is_j = (bus.fmt == 3'd5);
    enc  = '0;
    unique case (1'b1)
      is_r: enc = {bus.func7, bus.rs2, bus.rs1,
                   bus.func3, bus.rd, bus.opcode};
      is_i: enc = {bus.imm[11:0], bus.rs1,
                   bus.func3, bus.rd, bus.opcode};
      is_s: enc = {bus.imm[11:5], bus.rs2, bus.rs1,
                   bus.func3, bus.imm[4:0], bus.opcode};
      is_b: enc = {bus.imm[12], bus.imm[10:5],
                   bus.rs2, bus.rs1, bus.func3,
                   bus.imm[4:1], bus.imm[11], bus.opcode};
      is_u: enc = {bus.imm[31:12], bus.rd, bus.opcode};
      is_j: enc = {bus.imm[20], bus.imm[10:1],
                   bus.imm[11], bus.imm[19:12],
                   bus.rd, bus.opcode};
      default: enc = '0;
    endcase
    // B and J offsets are halfword multiples
    bad = !(is_r | is_i | is_s | is_b | is_u | is_j)
        | ((is_b | is_j) & bus.imm[0]);
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  assign bus.in_ready  = !full || flush;
  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? last_q
                               : mem_q[rd_ptr_q];
  assign bus.out_addr  = addr_q;
  assign bus.err_count = err_q;

  assign acc  = bus.in_valid && bus.in_ready;
  assign push = acc && !bad && !flush;
  assign pop  = bus.out_valid && bus.out_ready
             && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    last_d   = last_q;
    err_d    = err_q;
    if (push) begin
      mem_d[wr_ptr_q] = enc;
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
      addr_d   = addr_q + 32'd4;
      last_d   = mem_q[rd_ptr_q];
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
    if (acc && bad && !flush && err_q != 8'hFF)
      err_d = err_q + 8'd1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      addr_d   = BASE_ADDR;
      err_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      last_q   <= '0;
      err_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end
endmodule
